// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared types and constants for the UART command sequencer.
package is_pkg_uart_controller;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned ROM_W  = 128;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        MEM_WR,
        MEM_RD,
        RD_WAIT,
        SEND
    } cmd_state_t;

endpackage

// File: rtl/uart_cmd_ctrl_timer.sv
// Clearable saturating inter-byte counter; expired is high while the count sits at LIMIT-1.
module uart_cmd_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_q, expired_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        expired_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART read/write command sequencer driving a byte memory and returning one reply per command.
// Optional inter-byte timeout is built when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_ctrl #(
    parameter int unsigned DATA_W      = is_pkg_uart_controller::DATA_W,
    parameter int unsigned ADDR_W      = is_pkg_uart_controller::ADDR_W,
    parameter int unsigned DEPTH       = is_pkg_uart_controller::ROM_W,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              rx_err,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    import is_pkg_uart_controller::*;

    cmd_state_t        state_q, state_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic              busy_q, busy_d;
    logic              rx_byte_c;
    logic              nak_c;
    logic              tmo_expired;

    // An error in the same cycle as a byte discards the byte.
    assign rx_byte_c = rx_valid && !rx_err;

`ifdef UART_CMD_TIMEOUT_EN
    logic tmr_clr_c;
    logic tmr_en_c;

    assign tmr_clr_c = rx_valid || (state_q == IDLE);
    assign tmr_en_c  = (state_q == GET_ADDR) || (state_q == GET_DATA);

    uart_cmd_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr_c),
        .en      (tmr_en_c),
        .expired (tmo_expired)
    );
`else
    // No timer: the parameter only keeps the interface identical across builds.
    assign tmo_expired = (TIMEOUT_CYC == 32'd0) && 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        op_wr_d     = op_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        nak_c       = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_byte_c) begin
                    if ((rx_data == DATA_W'(OP_WR)) || (rx_data == DATA_W'(OP_RD))) begin
                        op_wr_d = (rx_data == DATA_W'(OP_WR));
                        state_d = GET_ADDR;
                    end else begin
                        nak_c = 1'b1;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_byte_c) begin
                    mem_addr_d = ADDR_W'(rx_data);
                    if (32'(rx_data) >= DEPTH) begin
                        nak_c = 1'b1;
                    end else if (op_wr_q) begin
                        state_d = GET_DATA;
                    end else begin
                        mem_re_d = 1'b1;
                        state_d  = MEM_RD;
                    end
                end else if (tmo_expired) begin
                    state_d = IDLE;
                end
            end
            GET_DATA: begin
                if (rx_byte_c) begin
                    mem_wdata_d = rx_data;
                    mem_we_d    = 1'b1;
                    state_d     = MEM_WR;
                end else if (tmo_expired) begin
                    state_d = IDLE;
                end
            end
            MEM_WR: begin
                tx_data_d  = DATA_W'(RSP_ACK);
                tx_start_d = !tx_busy;
                state_d    = SEND;
            end
            MEM_RD: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                tx_data_d  = mem_rdata;
                tx_start_d = !tx_busy;
                state_d    = SEND;
            end
            SEND: begin
                // tx_start is registered, so the launch decision is made one cycle ahead.
                if (tx_start_q) begin
                    state_d = IDLE;
                end else if (!tx_busy) begin
                    tx_start_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rx_err && (state_q != SEND)) begin
            nak_c = 1'b1;
        end

        if (nak_c) begin
            tx_data_d  = DATA_W'(RSP_NAK);
            tx_start_d = !tx_busy;
            mem_we_d   = 1'b0;
            mem_re_d   = 1'b0;
            state_d    = SEND;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_wr_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_wr_q     <= op_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            busy_q      <= busy_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_uart_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_err = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_rdata;
    logic       busy;

    logic       force_busy = 1'b0;
    int         tx_cnt;
    logic [7:0] mem_model [128];

    int n_run  = 0;
    int n_fail = 0;

    uart_cmd_ctrl #(
        .DATA_W      (8),
        .ADDR_W      (8),
        .DEPTH       (128),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_err    (rx_err),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Memory model: preloaded with addr ^ 0x5A on reset, read data one cycle after mem_re.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) mem_model[i] <= 8'(i) ^ 8'h5A;
            mem_rdata <= 8'h00;
        end else begin
            if (mem_we) mem_model[mem_addr[6:0]] <= mem_wdata;
            if (mem_re) mem_rdata <= mem_model[mem_addr[6:0]];
        end
    end

    // TX core model: busy for three cycles after each launch.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_cnt <= 0;
        else if (tx_start) tx_cnt <= 3;
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end
    assign tx_busy = force_busy || (tx_cnt != 0);

    typedef struct {
        logic [23:0] bytes;
        int          n;
        int          we_at;
        int          re_at;
        int          tx_at;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  reply;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || tx_busy) && k < 100) begin
            step();
            k++;
        end
        if (busy || tx_busy) check("wait_idle timeout", {30'd0, busy, tx_busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int         we_k, re_k, tx_k, bad;
        logic [7:0] got_addr, got_wdata, got_tx, b;

        vecs[0]  = '{24'h5710A5, 3, 1, 0, 2, 8'h10, 8'hA5, 8'h06};
        vecs[1]  = '{24'h521000, 2, 0, 1, 3, 8'h10, 8'h00, 8'hA5};
        vecs[2]  = '{24'h410000, 1, 0, 0, 1, 8'h00, 8'h00, 8'h15};
        vecs[3]  = '{24'h578000, 2, 0, 0, 1, 8'h00, 8'h00, 8'h15};
        vecs[4]  = '{24'h527F00, 2, 0, 1, 3, 8'h7F, 8'h00, 8'h25};
        vecs[5]  = '{24'h528000, 2, 0, 0, 1, 8'h00, 8'h00, 8'h15};
        vecs[6]  = '{24'h577F3C, 3, 1, 0, 2, 8'h7F, 8'h3C, 8'h06};
        vecs[7]  = '{24'h527F00, 2, 0, 1, 3, 8'h7F, 8'h00, 8'h3C};
        vecs[8]  = '{24'h52FF00, 2, 0, 0, 1, 8'h00, 8'h00, 8'h15};
        vecs[9]  = '{24'h570000, 3, 1, 0, 2, 8'h00, 8'h00, 8'h06};
        vecs[10] = '{24'h520000, 2, 0, 1, 3, 8'h00, 8'h00, 8'h00};
        vecs[11] = '{24'h522000, 2, 0, 1, 3, 8'h20, 8'h00, 8'h7A};

        // Reset values
        step();
        step();
        check("reset strobes", {28'd0, tx_start, mem_we, mem_re, busy}, 32'd0);
        check("reset tx_data", 32'(tx_data), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset mem_wdata", 32'(mem_wdata), 32'd0);
        rst_n = 1'b1;
        step();

        // Table-driven commands
        for (int i = 0; i < 12; i++) begin
            wait_idle();
            for (int j = 0; j < vecs[i].n; j++) begin
                b = vecs[i].bytes[23 - 8*j -: 8];
                send_byte(b);
            end
            we_k = 0; re_k = 0; tx_k = 0;
            got_addr = 8'h00; got_wdata = 8'h00; got_tx = 8'h00;
            for (int k = 1; k <= 8; k++) begin
                if (mem_we && we_k == 0) begin
                    we_k = k; got_addr = mem_addr; got_wdata = mem_wdata;
                end
                if (mem_re && re_k == 0) begin
                    re_k = k; got_addr = mem_addr;
                end
                if (tx_start && tx_k == 0) begin
                    tx_k = k; got_tx = tx_data;
                end
                step();
            end
            check($sformatf("v%0d we_at", i), 32'(we_k), 32'(vecs[i].we_at));
            check($sformatf("v%0d re_at", i), 32'(re_k), 32'(vecs[i].re_at));
            check($sformatf("v%0d tx_at", i), 32'(tx_k), 32'(vecs[i].tx_at));
            check($sformatf("v%0d reply", i), 32'(got_tx), 32'(vecs[i].reply));
            if (vecs[i].we_at != 0 || vecs[i].re_at != 0)
                check($sformatf("v%0d addr", i), 32'(got_addr), 32'(vecs[i].addr));
            if (vecs[i].we_at != 0)
                check($sformatf("v%0d wdata", i), 32'(got_wdata), 32'(vecs[i].wdata));
        end

        // rx_err alone in IDLE gives an immediate NAK
        wait_idle();
        rx_err = 1'b1;
        step();
        rx_err = 1'b0;
        check("err_idle tx_start", 32'(tx_start), 32'd1);
        check("err_idle tx_data", 32'(tx_data), 32'h15);

        // rx_err with rx_valid in GET_DATA, reply stalled behind a busy TX core
        wait_idle();
        send_byte(8'h57);
        send_byte(8'h10);
        force_busy = 1'b1;
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        rx_err   = 1'b1;
        step();
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            if (tx_start || mem_we || !busy) bad++;
            if (k != 49) step();
        end
        check("stall no start/we while busy", 32'(bad), 32'd0);
        force_busy = 1'b0;
        check("stall start on fall cycle", 32'(tx_start), 32'd0);
        step();
        check("stall start after fall", 32'(tx_start), 32'd1);
        check("stall reply", 32'(tx_data), 32'h15);
        step();
        check("stall idle after send", {30'd0, busy, tx_start}, 32'd0);

        // Bytes arriving in MEM_RD, RD_WAIT and SEND are dropped
        wait_idle();
        send_byte(8'h52);
        send_byte(8'h10);
        check("drop mem_re", 32'(mem_re), 32'd1);
        rx_data  = 8'h57;
        rx_valid = 1'b1;
        step();
        step();
        check("drop tx_start", 32'(tx_start), 32'd1);
        check("drop reply", 32'(tx_data), 32'hA5);
        step();
        rx_valid = 1'b0;
        check("drop back to idle", 32'(busy), 32'd0);

        // Silence after an opcode
        wait_idle();
        send_byte(8'h52);
        bad = 0;
`ifdef UART_CMD_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            if (!busy || tx_start || mem_re) bad++;
            step();
        end
        check("timeout busy during wait", 32'(bad), 32'd0);
        check("timeout idle at 17", 32'(busy), 32'd0);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (tx_start || busy) bad++;
            step();
        end
        check("timeout silent", 32'(bad), 32'd0);
`else
        for (int k = 0; k < 40; k++) begin
            if (!busy || tx_start || mem_re) bad++;
            step();
        end
        check("no timeout keeps waiting", 32'(bad), 32'd0);
        send_byte(8'h10);
        check("late addr mem_re", 32'(mem_re), 32'd1);
        step();
        step();
        check("late addr tx_start", 32'(tx_start), 32'd1);
        check("late addr reply", 32'(tx_data), 32'hA5);
`endif

        // Reset pulsed while in GET_DATA
        wait_idle();
        send_byte(8'h57);
        send_byte(8'h10);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset strobes", {28'd0, tx_start, mem_we, mem_re, busy}, 32'd0);
        check("midreset regs", {8'd0, tx_data, mem_addr, mem_wdata}, 32'd0);
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        step();
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            if (tx_start || mem_we || busy) bad++;
            step();
        end
        check("after reset quiet", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command sequencer between the UART receiver/transmitter cores and a 128-entry byte memory. It parses a byte-oriented read/write protocol arriving from the RX core and drives the memory port. It returns one reply byte per command through the TX core. It is the only master of the memory and the only source of `tx_start`.

## Interface
- `DATA_W`, 8: byte width of UART payload and memory data.
- `ADDR_W`, 8: width of the address byte and `mem_addr`.
- `DEPTH`, 128: number of valid memory locations; addresses >= `DEPTH` are rejected.
- `TIMEOUT_CYC`, 100000: inter-byte timeout in clock cycles (used only with `UART_CMD_TIMEOUT_EN`).

Ports:
- `clk` in 1: single clock; all logic rises on it.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in DATA_W: received byte, valid with `rx_valid`.
- `rx_valid` in 1: one-cycle pulse per received byte.
- `rx_err` in 1: one-cycle pulse on a parity or stop-bit error.
- `tx_data` out DATA_W: reply byte, held stable while `tx_start` is high.
- `tx_start` out 1: one-cycle pulse that launches a transmission.
- `tx_busy` in 1: high while the TX core is sending; it rises the cycle after `tx_start`.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: write data.
- `mem_we` out 1: one-cycle write strobe.
- `mem_re` out 1: one-cycle read strobe.
- `mem_rdata` in DATA_W: read data, valid one cycle after `mem_re`.
- `busy` out 1: high whenever the state machine is not IDLE.

## Operation
- Opcodes:
  - 0x57 'W': followed by an address byte, then a data byte.
  - 0x52 'R': followed by an address byte.
- Replies:
  - ACK 0x06 after a successful write.
  - The read data byte after a successful read.
  - NAK 0x15 for an unknown opcode, an address >= `DEPTH`, or `rx_err`.
- State machine `cmd_state_t`:
  - IDLE: on `rx_valid`, 'W' or 'R' -> GET_ADDR and the opcode is latched; any other byte -> SEND with NAK.
  - GET_ADDR: on `rx_valid`, latch the address.
    - Address >= `DEPTH` -> SEND with NAK.
    - 'W' -> GET_DATA.
    - 'R' -> MEM_RD.
  - GET_DATA: on `rx_valid`, latch the data byte -> MEM_WR.
  - MEM_WR: `mem_we`=1 for one cycle; reply register = ACK -> SEND.
  - MEM_RD: `mem_re`=1 for one cycle -> RD_WAIT.
  - RD_WAIT: reply register = `mem_rdata` -> SEND.
  - SEND: wait for `tx_busy`=0, then drive `tx_start`=1 for one cycle -> IDLE.
- `rx_err` in any state except SEND -> SEND with NAK. The partial command is discarded and there is no memory access.
- `rx_valid` and `rx_err` in the same cycle: the error wins and the byte is discarded.
- `rx_valid` while in MEM_WR, MEM_RD, RD_WAIT or SEND: the byte is dropped and the reply is unaffected.
- `mem_addr`/`mem_wdata` hold their last latched values; they are meaningful only while a strobe is high.

## Timing
- Reset values:
  - State = IDLE.
  - `tx_start`, `mem_we`, `mem_re`, `busy` = 0.
  - `tx_data`, `mem_addr`, `mem_wdata` = 0.
  - Timeout counter = 0.
- Write: data byte `rx_valid` at cycle N -> `mem_we` at N+1 -> `tx_start` at N+2 if `tx_busy`=0.
- Read: address byte `rx_valid` at N -> `mem_re` at N+1 -> `mem_rdata` sampled at N+2 -> `tx_start` at N+3 if `tx_busy`=0.
- NAK: `tx_start` at the cycle after the offending `rx_valid`/`rx_err` if `tx_busy`=0.
- `tx_start` is never asserted while `tx_busy`=1. SEND stalls with `busy`=1 until the TX core is idle.
- Reset asserted mid-command: immediate return to reset values; no strobe completes and no reply is sent.
- All outputs are registered.

## Configuration
- `UART_CMD_TIMEOUT_EN` defined:
  - In GET_ADDR and GET_DATA a counter increments each cycle and clears on `rx_valid`.
  - When it reaches `TIMEOUT_CYC`-1 -> IDLE silently, with no reply and no memory access.
  - The counter clears on entry to IDLE.
- Undefined: no counter is present, and the FSM waits indefinitely for the next byte.

## Structure
- The shared package `is_pkg_uart_controller` gains:
  - `cmd_state_t` (IDLE, GET_ADDR, GET_DATA, MEM_WR, MEM_RD, RD_WAIT, SEND).
  - Localparams `OP_WR`=8'h57, `OP_RD`=8'h52, `RSP_ACK`=8'h06, `RSP_NAK`=8'h15.
  - `DATA_W`, `ADDR_W` and `ROM_W` are reused as the parameter defaults (`DEPTH` = `ROM_W`).
- Sub-module `uart_cmd_timer`: clearable saturating inter-byte counter with a `expired` output. It is instantiated only under `UART_CMD_TIMEOUT_EN`.

## Test plan
- Bytes 0x57, 0x10, 0xA5 with `tx_busy`=0 -> `mem_we` with addr 0x10 and data 0xA5 one cycle after the third byte; `tx_start` with 0x06 the next cycle.
- Memory preloaded [0x10]=0xA5; bytes 0x52, 0x10 -> `mem_re` at N+1; `tx_start` with 0xA5 at N+3.
- Byte 0x41 -> `tx_start` with 0x15, no memory strobe.
- Bytes 0x57, 0x80 (>= `DEPTH`) -> NAK, no `mem_we`.
- Bytes 0x57, 0x10, then `rx_err` and `rx_valid` together -> NAK, no `mem_we`. With `tx_busy` held high for 50 cycles, `tx_start` appears only on the cycle after `tx_busy` falls.
- `UART_CMD_TIMEOUT_EN` with `TIMEOUT_CYC`=16: byte 0x52 then silence -> IDLE after 16 cycles with `busy`=0 and no `tx_start`. Separately, `rst_n` pulsed low in GET_DATA -> all outputs return to reset values immediately.
